// File: rtl/reg_if_rw_arb.sv
// Single-port arbiter merging split write/read register channels onto one bus.
// Define REG_IF_ARB_WR_PRIORITY_EN for fixed write priority on ties (default: round-robin).
module reg_if_rw_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] s_reg_wr_data,
    input  logic [STRB_WIDTH-1:0] s_reg_wr_strb,
    input  logic                  s_reg_wr_en,
    output logic                  s_reg_wr_wait,
    output logic                  s_reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0] s_reg_rd_addr,
    input  logic                  s_reg_rd_en,
    output logic [DATA_WIDTH-1:0] s_reg_rd_data,
    output logic                  s_reg_rd_wait,
    output logic                  s_reg_rd_ack,
    output logic [ADDR_WIDTH-1:0] m_reg_addr,
    output logic [DATA_WIDTH-1:0] m_reg_wr_data,
    output logic [STRB_WIDTH-1:0] m_reg_wr_strb,
    output logic                  m_reg_wr_en,
    output logic                  m_reg_rd_en,
    input  logic [DATA_WIDTH-1:0] m_reg_rd_data,
    input  logic                  m_reg_wait,
    input  logic                  m_reg_ack,
    output logic                  timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] RELOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          resp_rd;
    logic          pick_rd;
    logic          expire;

`ifndef REG_IF_ARB_WR_PRIORITY_EN
    logic last_rd;
`endif

    always_comb begin
        pick_rd = 1'b0;
        if (s_reg_rd_en && !s_reg_wr_en) begin
            pick_rd = 1'b1;
        end else if (s_reg_rd_en && s_reg_wr_en) begin
`ifdef REG_IF_ARB_WR_PRIORITY_EN
            pick_rd = 1'b0;
`else
            pick_rd = !last_rd;
`endif
        end
    end

    assign expire = (TIMEOUT > 0) && (cnt == '0);

    // A pending but blocked requester is told to wait so its own timer holds off.
    always_comb begin
        s_reg_wr_wait = 1'b0;
        s_reg_rd_wait = 1'b0;
        unique case (state)
            WR: begin
                s_reg_wr_wait = m_reg_wait;
                s_reg_rd_wait = s_reg_rd_en;
            end
            RD: begin
                s_reg_rd_wait = m_reg_wait;
                s_reg_wr_wait = s_reg_wr_en;
            end
            RESP: begin
                s_reg_wr_wait = s_reg_wr_en && resp_rd;
                s_reg_rd_wait = s_reg_rd_en && !resp_rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            resp_rd       <= 1'b0;
            m_reg_addr    <= '0;
            m_reg_wr_data <= '0;
            m_reg_wr_strb <= '0;
            m_reg_wr_en   <= 1'b0;
            m_reg_rd_en   <= 1'b0;
            s_reg_rd_data <= '0;
            s_reg_wr_ack  <= 1'b0;
            s_reg_rd_ack  <= 1'b0;
            timeout_err   <= 1'b0;
`ifndef REG_IF_ARB_WR_PRIORITY_EN
            last_rd       <= 1'b1;
`endif
        end else begin
            s_reg_wr_ack <= 1'b0;
            s_reg_rd_ack <= 1'b0;
            timeout_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_reg_wr_en || s_reg_rd_en) begin
                        cnt           <= RELOAD;
                        resp_rd       <= pick_rd;
                        m_reg_addr    <= pick_rd ? s_reg_rd_addr : s_reg_wr_addr;
                        m_reg_wr_data <= pick_rd ? '0 : s_reg_wr_data;
                        m_reg_wr_strb <= pick_rd ? '0 : s_reg_wr_strb;
                        m_reg_wr_en   <= !pick_rd;
                        m_reg_rd_en   <= pick_rd;
                        state         <= pick_rd ? RD : WR;
`ifndef REG_IF_ARB_WR_PRIORITY_EN
                        if (s_reg_wr_en && s_reg_rd_en) begin
                            last_rd <= pick_rd;
                        end
`endif
                    end
                end
                WR, RD: begin
                    // Ack beats expiry; wait beats expiry by reloading first.
                    if (m_reg_ack || (!m_reg_wait && expire)) begin
                        m_reg_wr_en <= 1'b0;
                        m_reg_rd_en <= 1'b0;
                        timeout_err <= !m_reg_ack;
                        state       <= RESP;
                        if (state == RD) begin
                            s_reg_rd_ack  <= 1'b1;
                            s_reg_rd_data <= m_reg_ack ? m_reg_rd_data : '0;
                        end else begin
                            s_reg_wr_ack <= 1'b1;
                        end
                    end else if (m_reg_wait) begin
                        cnt <= RELOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_if_rw_arb.md
Name: reg_if_rw_arb

Overview:
- Merges the split write/read register-interface channels into one single-port register bus for register banks with a single access port.
- Sits between the AXI-lite-to-register bridge and a single-port register bank.
- Arbitrates write and read requests, holds the grant until the target acks, forwards wait back-pressure and enforces a local timeout.

Parameters:
DATA_WIDTH, 32, register data width in bits
ADDR_WIDTH, 32, register address width in bits
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
TIMEOUT, 16, cycles without ack/wait before forced completion; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset
s_reg_wr_addr  in  ADDR_WIDTH  write address from upstream
s_reg_wr_data  in  DATA_WIDTH  write data
s_reg_wr_strb  in  STRB_WIDTH  write byte strobes
s_reg_wr_en  in  1  write request, held until s_reg_wr_ack
s_reg_wr_wait  out  1  write extend-timeout indication to upstream
s_reg_wr_ack  out  1  write completion pulse
s_reg_rd_addr  in  ADDR_WIDTH  read address from upstream
s_reg_rd_en  in  1  read request, held until s_reg_rd_ack
s_reg_rd_data  out  DATA_WIDTH  read data, valid with s_reg_rd_ack
s_reg_rd_wait  out  1  read extend-timeout indication to upstream
s_reg_rd_ack  out  1  read completion pulse
m_reg_addr  out  ADDR_WIDTH  shared address to target
m_reg_wr_data  out  DATA_WIDTH  write data to target
m_reg_wr_strb  out  STRB_WIDTH  write strobes to target
m_reg_wr_en  out  1  write access active
m_reg_rd_en  out  1  read access active
m_reg_rd_data  in  DATA_WIDTH  target read data
m_reg_wait  in  1  target requests timeout extension
m_reg_ack  in  1  target completion
timeout_err  out  1  one-cycle pulse when an access is force-completed

Behaviour:
- Interface rule (already decided): single clock clk; rst is synchronous and active-high.
- On reset:
  - All outputs are 0.
  - FSM goes to IDLE and the timeout counter is 0.
  - last_grant = READ, so the first tie goes to the write.
  - rst asserted mid-access abandons the access and issues no ack.
- FSM states: IDLE, WR, RD, RESP.
- IDLE:
  - Only s_reg_wr_en set: go to WR.
  - Only s_reg_rd_en set: go to RD.
  - Both set: grant the side opposite last_grant (round-robin), then update last_grant.
  - On the grant edge, m_reg_addr, m_reg_wr_data and m_reg_wr_strb are registered from the granted side, and m_reg_*_en rises. Latency from request to target enable is 1 cycle.
- WR/RD:
  - m_reg_wr_en or m_reg_rd_en is held at 1 and all m_ outputs are stable.
  - On m_reg_ack: drop the enable, capture m_reg_rd_data into s_reg_rd_data (RD only), go to RESP.
- RESP:
  - s_reg_wr_ack or s_reg_rd_ack is 1 for exactly this one cycle, then return to IDLE.
  - Upstream must deassert en in the cycle after the ack. IDLE re-samples en, so back-to-back accesses have a 3-cycle minimum period.
  - s_reg_rd_data holds its value until the next read completes.
- Wait forwarding:
  - The granted side's s_reg_*_wait equals m_reg_wait (combinational).
  - A requester that is pending but not granted sees s_reg_*_wait = 1, so its own upstream timeout does not fire while blocked.
  - Otherwise wait is 0.
- Timeout (TIMEOUT > 0):
  - The counter loads TIMEOUT-1 on grant.
  - While m_reg_wait = 1 it reloads to TIMEOUT-1.
  - Otherwise it decrements each cycle in WR/RD.
  - If it is 0 and m_reg_ack = 0: drop the enable, set s_reg_rd_data = 0 for a read, pulse timeout_err, go to RESP (the ack is still issued).
  - The counter width is $clog2(TIMEOUT+1).
  - If ack and expiry coincide, ack wins and timeout_err stays 0.
- An m_reg_ack seen in IDLE or RESP is ignored.
- A requester dropping en while granted is illegal; the behaviour is unspecified, but the FSM must still terminate via ack or timeout.

Optional Feature:
- Macro REG_IF_ARB_WR_PRIORITY_EN.
- Defined: a tie in IDLE always grants the write; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Write-only: wr_en, addr 0x10, data 0xA5A5_0001, strb 0xF; target acks 2 cycles after m_reg_wr_en → m_reg_wr_en high 1 cycle after request, for 2 cycles; s_reg_wr_ack one pulse; timeout_err = 0.
- Read-only: rd_en, addr 0x20; target returns 0x1234_5678 with ack → s_reg_rd_data = 0x1234_5678 in the same cycle as s_reg_rd_ack, held afterwards.
- Simultaneous wr+rd after reset, repeated 4 times:
  - Round-robin build: grant order WR, RD, WR, RD.
  - REG_IF_ARB_WR_PRIORITY_EN build: the write is always granted first.
  - The blocked side's s_reg_*_wait = 1 for the whole time it is blocked.
- Timeout, TIMEOUT=16, target never acks → enable drops after 16 cycles; rd_data = 0; rd_ack and timeout_err pulse together.
- Wait extension: target holds m_reg_wait for 40 cycles, then acks → no timeout; s_reg_rd_wait mirrors m_reg_wait; normal ack.
- Reset asserted 2 cycles into a WR access → next cycle all m_ and s_ outputs are 0 and no ack; a new request after reset completes normally.
